// File: rtl/switch_countdown_timer.sv
// switch_countdown_timer: switch-loaded 8-bit countdown with debounced load/run buttons (optional AUTO_RELOAD_EN)
module switch_countdown_timer #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_run,
    output logic [7:0] led,
    output logic       done,
    output logic       running
`ifdef AUTO_RELOAD_EN
    ,
    output logic       wrap
`endif
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    logic [1:0] raw, s0, s1, db, db_q, press;
    logic [DW-1:0] dcnt [2];
    logic load, run, tick;
    state_t state, state_n;
    logic [7:0] count, count_n;
    logic [PW-1:0] presc, presc_n;
    logic blink, blink_n;
`ifdef AUTO_RELOAD_EN
    logic [7:0] reload;
    logic wrap_n;
`endif

    assign raw   = {btn_run, btn_load};
    assign press = db & ~db_q;
    assign load  = press[0];
    assign run   = press[1];
    assign tick  = (state == RUN || state == DONE) && presc == PW'(TICK_DIV - 1);
    assign led   = state == DONE ? {8{blink}} : count;

    // synchronize both buttons, accept a new level only after it has held long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            s0   <= '0;
            s1   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            s0   <= raw;
            s1   <= s0;
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s1[i] == db[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]   <= s1[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // next state: load overrides everything; a tick that finishes the count beats a pause
    always_comb begin
        state_n = state;
        count_n = count;
        blink_n = blink;
        presc_n = (state == RUN || state == DONE) ? (tick ? '0 : presc + 1'b1) : presc;
`ifdef AUTO_RELOAD_EN
        wrap_n  = 1'b0;
`endif
        if (load) begin
            count_n = sw;
            presc_n = '0;
            blink_n = 1'b0;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (run && count != 8'd0) state_n = RUN;
                RUN: begin
                    if (tick && count > 8'd1) begin
                        count_n = count - 8'd1;
                    end else if (tick && count == 8'd1) begin
`ifdef AUTO_RELOAD_EN
                        count_n = reload;
                        wrap_n  = 1'b1;
`else
                        count_n = '0;
                        state_n = DONE;
                        presc_n = '0;
`endif
                    end
                    if (run && state_n == RUN) state_n = PAUSE;
                end
                PAUSE: if (run) state_n = RUN;
                DONE: if (tick) blink_n = ~blink;
            endcase
        end
    end

    // state, count, prescaler and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            presc   <= '0;
            blink   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload  <= '0;
            wrap    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            count   <= count_n;
            presc   <= presc_n;
            blink   <= blink_n;
            running <= state_n == RUN;
            done    <= state_n == DONE;
`ifdef AUTO_RELOAD_EN
            reload  <= load ? sw : reload;
            wrap    <= wrap_n;
`endif
        end
    end
endmodule

// File: tb/tb_switch_countdown_timer.sv
// tb_switch_countdown_timer: directed + random bench with an elapsed-time reference model
module tb_switch_countdown_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] sw = '0;
    logic btn_load = 1'b0;
    logic btn_run = 1'b0;
    logic [7:0] led;
    logic done, running;
`ifdef AUTO_RELOAD_EN
    logic wrap;
`endif

    switch_countdown_timer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load), .btn_run(btn_run),
        .led(led), .done(done), .running(running)
`ifdef AUTO_RELOAD_EN
        , .wrap(wrap)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // model: c = loaded value, r = clock cycles spent counting, mode 0 idle / 1 run / 2 pause
    int c = 0;
    int r = 0;
    int mode = 0;
    bit wr = 0;
    int load_at[$];
    int run_at[$];

    function automatic bit m_done();
`ifdef AUTO_RELOAD_EN
        return 1'b0;
`else
        return mode == 1 && r >= 4 * c;
`endif
    endfunction

    function automatic logic [7:0] m_led();
        if (mode == 0) return 8'(c);
`ifdef AUTO_RELOAD_EN
        return 8'(c - (r / 4) % c);
`else
        if (m_done()) return (((r - 4 * c) / 4) % 2) ? 8'hFF : 8'h00;
        return 8'(c - r / 4);
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit ld, rn;
        @(posedge clk);
        cyc++;
        ld = 0;
        rn = 0;
        if (load_at.size() > 0 && load_at[0] == cyc) begin ld = 1; void'(load_at.pop_front()); end
        if (run_at.size() > 0 && run_at[0] == cyc) begin rn = 1; void'(run_at.pop_front()); end
        wr = 0;
        if (reset) begin
            c = 0; r = 0; mode = 0;
        end else begin
            if (mode == 1) begin
                r++;
                wr = (r % (4 * c)) == 0;
            end
            if (ld) begin
                c = sw; r = 0; mode = 0; wr = 0;
            end else if (rn) begin
                if (mode == 0 && c != 0) mode = 1;
                else if (mode == 1 && !m_done()) mode = 2;
                else if (mode == 2) mode = 1;
            end
        end
        #1;
        check("led", led, m_led());
        check("done", 8'(done), 8'(m_done()));
        check("running", 8'(running), 8'(mode == 1 && !m_done()));
`ifdef AUTO_RELOAD_EN
        check("wrap", 8'(wrap), 8'(wr));
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // 3-cycle clean press; the model sees it 6 edges after the raw rise
    task automatic press(input bit ld, input bit rn);
        if (ld) begin btn_load = 1'b1; load_at.push_back(cyc + 6); end
        if (rn) begin btn_run = 1'b1; run_at.push_back(cyc + 6); end
        idle(3);
        btn_load = 1'b0;
        btn_run = 1'b0;
        idle(3);
    endtask

    initial begin
        // reset with buttons chattering
        reset = 1'b1;
        repeat (2) begin
            btn_load = 1'($urandom);
            btn_run = 1'($urandom);
            step();
        end
        btn_load = 1'b0;
        btn_run = 1'b0;
        reset = 1'b0;
        idle(10);
        check("reset_led", led, 8'h00);

        // bounce: short glitch then a long press
        btn_load = 1'b1;
        idle(2);
        btn_load = 1'b0;
        idle(3);
        sw = 8'h05;
        btn_load = 1'b1;
        load_at.push_back(cyc + 6);
        idle(10);
        sw = 8'h09;
        btn_load = 1'b0;
        idle(8);
        check("bounce_led", led, 8'h05);

        // countdown to done, blink, then reload out of done
        sw = 8'h03;
        press(1, 0);
        press(0, 1);
        idle(40);
        check("done_flag", 8'(done), 8'(m_done()));
        sw = 8'h02;
        press(1, 0);

        // pause/resume
        sw = 8'h0A;
        press(1, 0);
        press(0, 1);
        press(0, 1);
        idle(20);
        press(0, 1);
        idle(12);

        // zero load, then same-cycle load and run while running
        sw = 8'h00;
        press(1, 0);
        press(0, 1);
        sw = 8'h05;
        press(1, 0);
        press(0, 1);
        idle(5);
        sw = 8'h07;
        press(1, 1);
        idle(4);
        check("prio_led", led, 8'h07);

        // reset mid-count
        press(0, 1);
        idle(7);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(4);
        check("midreset_led", led, 8'h00);

        // random operation sequences
        for (int i = 0; i < 8; i++) begin
            sw = 8'($urandom_range(0, 6));
            press(1, 0);
            press(0, 1);
            for (int j = 0; j < 6; j++) begin
                case ($urandom_range(0, 3))
                    0: idle($urandom_range(1, 15));
                    1: press(0, 1);
                    2: begin sw = 8'($urandom_range(1, 6)); press(1, 0); end
                    default: begin sw = 8'($urandom_range(1, 6)); press(1, 1); end
                endcase
            end
            idle($urandom_range(0, 30));
        end

`ifdef AUTO_RELOAD_EN
        sw = 8'h02;
        press(1, 0);
        press(0, 1);
        idle(40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
